// File: rtl/esl_clk_check_pkg.sv
// ============================================================================
// Module  : esl_clk_check_pkg
// Brief   : Register map and bit indices shared by the clock-check blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package esl_clk_check_pkg;

    localparam int c_ADDR_CTRL     = 0;
    localparam int c_ADDR_STATUS   = 1;
    localparam int c_ADDR_REF_TC   = 2;
    localparam int c_ADDR_IRQ_MASK = 3;

    // Per-channel register block: COUNT, MIN, MAX, reserved.
    localparam int c_CH_BASE   = 4;
    localparam int c_CH_STRIDE = 4;
    localparam int c_OFS_COUNT = 0;
    localparam int c_OFS_MIN   = 1;
    localparam int c_OFS_MAX   = 2;

    localparam int c_CTRL_ENABLE_BIT  = 0;
    localparam int c_CTRL_CLR_ALL_BIT = 1;

    localparam int c_STATUS_VALID_BIT = 31;

endpackage

`default_nettype wire

// File: rtl/esl_clk_check_ch.sv
// ============================================================================
// Module  : esl_clk_check_ch
// Brief   : One monitored channel: saturating tick counter, window capture,
//           min/max compare and sticky error flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module esl_clk_check_ch #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             tick,
    input  logic             win_end,
    input  logic [CNT_W-1:0] min_lim,
    input  logic [CNT_W-1:0] max_lim,
    input  logic             clr_low,
    input  logic             clr_high,
    output logic [CNT_W-1:0] count,
    output logic             low_err,
    output logic             high_err
);

    localparam logic [CNT_W-1:0] c_SAT = '1;

    logic [CNT_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_low_err;
    logic             r_high_err;
    logic [CNT_W-1:0] w_final;

    // Includes a tick arriving on the terminal window cycle.
    always_comb begin
        w_final = r_tick_cnt;
        if (tick && (r_tick_cnt != c_SAT)) begin
            w_final = r_tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !run || win_end) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_final;
        end
    end

    // A capture that sets a flag beats a simultaneous clear of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_low_err  <= 1'b0;
            r_high_err <= 1'b0;
        end else begin
            if (win_end) begin
                r_count <= w_final;
            end
            r_low_err  <= (r_low_err  & ~clr_low)  | (win_end & (w_final < min_lim));
            r_high_err <= (r_high_err & ~clr_high) | (win_end & (w_final > max_lim));
        end
    end

    assign count    = r_count;
    assign low_err  = r_low_err;
    assign high_err = r_high_err;

endmodule

`default_nettype wire

// File: rtl/esl_clk_check_mc.sv
// ============================================================================
// Module  : esl_clk_check_mc
// Brief   : Multi-channel clock-frequency checker with registered Avalon-MM
//           CSR slave, shared reference window and maskable interrupt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module esl_clk_check_mc
    import esl_clk_check_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 24,
    parameter int REF_TC_RST = 1000,
    parameter int ADDR_W     = $clog2(4 + 4 * NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] cut_tick,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              csr_readdatavalid,
    output logic              irq
);

    localparam int c_NE = 2 * NUM_CH;

    logic             r_enable;
    logic [CNT_W-1:0] r_ref_tc;
    logic [CNT_W-1:0] r_win_len;
    logic [CNT_W-1:0] r_win_cnt;
    logic [c_NE-1:0]  r_irq_mask;
    logic             r_valid;
    logic             r_irq;
    logic [31:0]      r_readdata;
    logic             r_readdatavalid;

    logic [CNT_W-1:0] r_min   [NUM_CH];
    logic [CNT_W-1:0] r_max   [NUM_CH];
    logic [CNT_W-1:0] w_count [NUM_CH];

    logic [c_NE-1:0]  w_err;
    logic [c_NE-1:0]  w_clr;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic             w_wr_ref;
    logic             w_wr_mask;
    logic             w_clr_all;
    logic             w_start;
    logic             w_win_end;
    logic [CNT_W-1:0] w_ref_len;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    assign w_wr_ctrl   = csr_write && (csr_addr == ADDR_W'(c_ADDR_CTRL));
    assign w_wr_status = csr_write && (csr_addr == ADDR_W'(c_ADDR_STATUS));
    assign w_wr_ref    = csr_write && (csr_addr == ADDR_W'(c_ADDR_REF_TC));
    assign w_wr_mask   = csr_write && (csr_addr == ADDR_W'(c_ADDR_IRQ_MASK));
    assign w_clr_all   = w_wr_ctrl && csr_writedata[c_CTRL_CLR_ALL_BIT];
    assign w_start     = w_wr_ctrl && csr_writedata[c_CTRL_ENABLE_BIT] && !r_enable;
    assign w_clr       = w_clr_all   ? {c_NE{1'b1}} :
                         w_wr_status ? csr_writedata[c_NE-1:0] : '0;

    // A programmed length of 0 runs as a one-cycle window.
    assign w_ref_len = (r_ref_tc == '0) ? CNT_W'(1) : r_ref_tc;
    assign w_win_end = r_enable && (r_win_cnt == r_win_len - CNT_W'(1));

    assign w_unused_wdata = ^csr_writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_cnt <= '0;
            r_win_len <= CNT_W'(1);
        end else if (!r_enable) begin
            r_win_cnt <= '0;
            if (w_start) begin
                r_win_len <= w_ref_len;
            end
        end else if (w_win_end) begin
            r_win_cnt <= '0;
            r_win_len <= w_ref_len;
        end else begin
            r_win_cnt <= r_win_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable   <= 1'b0;
            r_ref_tc   <= CNT_W'(REF_TC_RST);
            r_irq_mask <= '0;
            r_valid    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= csr_writedata[c_CTRL_ENABLE_BIT];
            end
            if (w_wr_ref) begin
                r_ref_tc <= csr_writedata[CNT_W-1:0];
            end
            if (w_wr_mask) begin
                r_irq_mask <= csr_writedata[c_NE-1:0];
            end
            r_valid <= w_win_end | (r_valid & ~w_clr_all);
            r_irq   <= |(w_err & r_irq_mask);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(c_CH_BASE + c_CH_STRIDE * g);

        logic w_wr_min;
        logic w_wr_max;

        assign w_wr_min = csr_write && (csr_addr == c_BASE + ADDR_W'(c_OFS_MIN));
        assign w_wr_max = csr_write && (csr_addr == c_BASE + ADDR_W'(c_OFS_MAX));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_min[g] <= '0;
                r_max[g] <= '1;
            end else begin
                if (w_wr_min) begin
                    r_min[g] <= csr_writedata[CNT_W-1:0];
                end
                if (w_wr_max) begin
                    r_max[g] <= csr_writedata[CNT_W-1:0];
                end
            end
        end

        esl_clk_check_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .run      (r_enable),
            .tick     (cut_tick[g]),
            .win_end  (w_win_end),
            .min_lim  (r_min[g]),
            .max_lim  (r_max[g]),
            .clr_low  (w_clr[2*g]),
            .clr_high (w_clr[2*g+1]),
            .count    (w_count[g]),
            .low_err  (w_err[2*g]),
            .high_err (w_err[2*g+1])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (csr_addr == ADDR_W'(c_ADDR_CTRL)) begin
            w_rdata[c_CTRL_ENABLE_BIT] = r_enable;
        end else if (csr_addr == ADDR_W'(c_ADDR_STATUS)) begin
            w_rdata[c_NE-1:0]          = w_err;
            w_rdata[c_STATUS_VALID_BIT] = r_valid;
        end else if (csr_addr == ADDR_W'(c_ADDR_REF_TC)) begin
            w_rdata[CNT_W-1:0] = r_ref_tc;
        end else if (csr_addr == ADDR_W'(c_ADDR_IRQ_MASK)) begin
            w_rdata[c_NE-1:0] = r_irq_mask;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (csr_addr == ADDR_W'(c_CH_BASE + c_CH_STRIDE * c + c_OFS_COUNT)) begin
                w_rdata[CNT_W-1:0] = w_count[c];
            end else if (csr_addr == ADDR_W'(c_CH_BASE + c_CH_STRIDE * c + c_OFS_MIN)) begin
                w_rdata[CNT_W-1:0] = r_min[c];
            end else if (csr_addr == ADDR_W'(c_CH_BASE + c_CH_STRIDE * c + c_OFS_MAX)) begin
                w_rdata[CNT_W-1:0] = r_max[c];
            end
        end
    end

    // Read data reflects state before any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= csr_read;
            if (csr_read) begin
                r_readdata <= w_rdata;
            end
        end
    end

    assign csr_readdata      = r_readdata;
    assign csr_readdatavalid = r_readdatavalid;
    assign irq               = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_esl_clk_check_mc.sv
// ============================================================================
// Module  : tb_esl_clk_check_mc
// Brief   : Directed, table-driven bench for the multi-channel clock checker.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_esl_clk_check_mc;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 5;

    typedef struct {
        int          addr;
        logic [31:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] cut_tick;
    logic [ADDR_W-1:0] csr_addr;
    logic              csr_read;
    logic              csr_write;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;
    logic              csr_readdatavalid;
    logic              irq;

    logic              sel8;
    logic              rd_m, wr_m, rd8, wr8;
    logic [31:0]       rdata8;
    logic              rdv8;
    logic              irq8;
    logic [0:0]        tick8;

    int                checks   = 0;
    int                failures = 0;
    int unsigned       period [NUM_CH];
    int unsigned       tcnt = 0;
    vec_t              rst_tab [22];
    logic [31:0]       rdv;

    assign rd_m  = csr_read  & ~sel8;
    assign wr_m  = csr_write & ~sel8;
    assign rd8   = csr_read  &  sel8;
    assign wr8   = csr_write &  sel8;
    assign tick8 = 1'b1;

    esl_clk_check_mc #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (24),
        .REF_TC_RST (1000)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cut_tick          (cut_tick),
        .csr_addr          (csr_addr),
        .csr_read          (rd_m),
        .csr_write         (wr_m),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .irq               (irq)
    );

    esl_clk_check_mc #(
        .NUM_CH     (1),
        .CNT_W      (8),
        .REF_TC_RST (255)
    ) dut8 (
        .clk               (clk),
        .reset             (reset),
        .cut_tick          (tick8),
        .csr_addr          (csr_addr[2:0]),
        .csr_read          (rd8),
        .csr_write         (wr8),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (rdata8),
        .csr_readdatavalid (rdv8),
        .irq               (irq8)
    );

    always #5 clk = ~clk;

    // Tick pattern generator: channel c pulses once every period[c] clocks.
    always @(negedge clk) begin
        tcnt++;
        for (int c = 0; c < NUM_CH; c++) begin
            cut_tick[c] = (period[c] != 0) && ((tcnt % period[c]) == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        csr_addr      = ADDR_W'(a);
        csr_writedata = d;
        csr_write     = 1'b1;
        step(1);
        csr_write     = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        csr_addr = ADDR_W'(a);
        csr_read = 1'b1;
        step(1);
        csr_read = 1'b0;
        d = sel8 ? rdata8 : csr_readdata;
        chk($sformatf("rdvalid@%0d", a), {31'd0, sel8 ? rdv8 : csr_readdatavalid}, 32'd1);
    endtask

    task automatic rdchk(input string name, input int a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    task automatic check_reset_table(input string tag);
        for (int i = 0; i < 22; i++) begin
            rdchk($sformatf("%s_addr%0d", tag, rst_tab[i].addr), rst_tab[i].addr, rst_tab[i].exp);
        end
    endtask

    initial begin
        rst_tab[0] = '{0, 32'h0};
        rst_tab[1] = '{1, 32'h0};
        rst_tab[2] = '{2, 32'd1000};
        rst_tab[3] = '{3, 32'h0};
        for (int c = 0; c < NUM_CH; c++) begin
            rst_tab[4 + 4*c] = '{4 + 4*c, 32'h0};
            rst_tab[5 + 4*c] = '{5 + 4*c, 32'h0};
            rst_tab[6 + 4*c] = '{6 + 4*c, 32'h00FF_FFFF};
            rst_tab[7 + 4*c] = '{7 + 4*c, 32'h0};
        end
        rst_tab[20] = '{20, 32'h0};
        rst_tab[21] = '{31, 32'h0};

        reset = 1'b1; sel8 = 1'b0; csr_addr = '0; csr_read = 1'b0;
        csr_write = 1'b0; csr_writedata = '0; cut_tick = '0;
        for (int c = 0; c < NUM_CH; c++) period[c] = 0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdv", {31'd0, csr_readdatavalid}, 32'd0);
        check_reset_table("rst");

        // In-range, low and high captures over a 100-cycle window
        period[0] = 4; period[1] = 10; period[2] = 1; period[3] = 0;
        wr(2, 100); wr(5, 20); wr(6, 30); wr(9, 20); wr(14, 50);
        wr(0, 1);
        step(110);
        rdchk("count0", 4, 25);
        rdchk("count1", 8, 10);
        rdchk("count2", 12, 100);
        rdchk("count3", 16, 0);
        rdchk("status_a", 1, 32'h8000_0024);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        wr(0, 0);
        wr(3, 32'h20);
        chk("irq_lag", {31'd0, irq}, 32'd0);
        step(1);
        chk("irq_set", {31'd0, irq}, 32'd1);
        wr(1, 32'h20);
        step(1);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rdchk("status_w1c", 1, 32'h8000_0004);

        // clr_all, one-cycle window, REF_TC=0
        wr(0, 2);
        rdchk("status_clrall", 1, 32'h0);
        wr(2, 1); wr(0, 1); step(5); wr(0, 0);
        rdchk("win1_count2", 12, 1);
        wr(2, 5); wr(0, 1); step(12); wr(0, 0);
        rdchk("win5_count2", 12, 5);
        wr(2, 0);
        rdchk("ref_tc_zero", 2, 0);
        wr(0, 1); step(5); wr(0, 0);
        rdchk("win0_count2", 12, 1);

        // REF_TC rewritten mid-window takes effect from the next window
        wr(2, 100);
        wr(0, 1);
        step(29);
        wr(2, 50);
        step(88);
        rdchk("midwin_first", 12, 100);
        step(40);
        rdchk("midwin_second", 12, 50);
        wr(0, 0);

        // Enable dropped mid-window: no capture, counters restart on re-enable
        period[2] = 2;
        wr(0, 1);
        step(39);
        wr(0, 0);
        step(100);
        rdchk("disable_keep", 12, 50);
        rd(1, rdv);
        chk("disable_valid", rdv & 32'h8000_0000, 32'h8000_0000);
        wr(0, 1);
        step(60);
        rdchk("reenable_fresh", 12, 25);

        // Reset mid-window (enable still set)
        step(39);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        check_reset_table("midrst");

        // Capture setting a flag wins over a W1C in the same cycle
        period[0] = 0; period[1] = 0; period[2] = 1; period[3] = 0;
        wr(2, 20); wr(14, 5);
        wr(0, 1);
        step(19);
        wr(1, 32'h20);
        wr(0, 0);
        rdchk("race_set_wins", 1, 32'h8000_0020);
        wr(1, 32'h20);
        rdchk("race_then_clr", 1, 32'h8000_0000);

        // Narrow-counter instance: 255-cycle window, REF_TC truncation
        sel8 = 1'b1;
        wr(0, 1);
        step(270);
        rdchk("cnt8_count", 4, 255);
        wr(0, 0);
        wr(2, 300);
        rdchk("cnt8_ref_trunc", 2, 32'h2C);
        chk("cnt8_irq", {31'd0, irq8}, 32'd0);
        sel8 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
